// File: rtl/iorq_rw_fsm.sv
// Z8S180 I/O-cycle decoder: one-cycle read/write ticks for NPORTS ports from BASE.
// Define IORQ_SYNC_EN to pass the bus strobes through a 2-flop synchroniser.
module iorq_rw_fsm #(
    parameter int                ADDR_W = 8,
    parameter logic [ADDR_W-1:0] BASE   = 8'h40,
    parameter int                NPORTS = 4,
    parameter int                QUAL   = 1,
    localparam int               PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic              phi,
    input  logic              reset,
    input  logic              iorq,
    input  logic              rd,
    input  logic              wr,
    input  logic              m1,
    input  logic [ADDR_W-1:0] addr,
    output logic [NPORTS-1:0] wr_tick,
    output logic [NPORTS-1:0] rd_tick,
    output logic              rd_oe,
    output logic [PW-1:0]     port,
    output logic              rw_err
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, QUALIFY, BUSY} state_t;

    localparam logic [ADDR_W:0] LO = {1'b0, BASE};
    localparam logic [ADDR_W:0] HI = LO + (ADDR_W+1)'(NPORTS);

`ifdef IORQ_SYNC_EN
    localparam int VLD_W = 2;
    logic              r_iorq_m, r_rd_m, r_wr_m, r_m1_m;
    logic [ADDR_W-1:0] r_addr_m;
`else
    localparam int VLD_W = 1;
`endif

    logic              r_iorq_s, r_rd_s, r_wr_s, r_m1_s;
    logic [ADDR_W-1:0] r_addr_s;
    // Marks when the sample registers hold real bus samples rather than reset values,
    // so WAIT_IDLE cannot mistake the reset contents for an idle bus.
    logic [VLD_W-1:0]  r_vld;

    always_ff @(posedge phi or negedge reset) begin
        if (!reset) begin
`ifdef IORQ_SYNC_EN
            r_iorq_m <= 1'b0;
            r_rd_m   <= 1'b0;
            r_wr_m   <= 1'b0;
            r_m1_m   <= 1'b0;
            r_addr_m <= '0;
`endif
            r_iorq_s <= 1'b0;
            r_rd_s   <= 1'b0;
            r_wr_s   <= 1'b0;
            r_m1_s   <= 1'b0;
            r_addr_s <= '0;
            r_vld    <= '0;
        end else begin
`ifdef IORQ_SYNC_EN
            r_iorq_m <= iorq;
            r_rd_m   <= rd;
            r_wr_m   <= wr;
            r_m1_m   <= m1;
            r_addr_m <= addr;
            r_iorq_s <= r_iorq_m;
            r_rd_s   <= r_rd_m;
            r_wr_s   <= r_wr_m;
            r_m1_s   <= r_m1_m;
            r_addr_s <= r_addr_m;
`else
            r_iorq_s <= iorq;
            r_rd_s   <= rd;
            r_wr_s   <= wr;
            r_m1_s   <= m1;
            r_addr_s <= addr;
`endif
            r_vld    <= (r_vld << 1) | VLD_W'(1);
        end
    end

    logic          w_vld, w_hit, w_qual;
    logic [PW-1:0] w_idx;

    assign w_vld  = r_vld[VLD_W-1];
    assign w_hit  = ({1'b0, r_addr_s} >= LO) && ({1'b0, r_addr_s} < HI);
    assign w_idx  = PW'(r_addr_s - BASE);
    assign w_qual = r_iorq_s && !r_m1_s && w_hit && (r_rd_s ^ r_wr_s);

    state_t            r_state, w_state_nx;
    logic [2:0]        r_cnt, w_cnt_nx;
    logic              r_dir, w_dir_nx;
    logic [PW-1:0]     r_idx, w_idx_nx;
    logic [NPORTS-1:0] r_wr_tick, w_wr_tick_nx;
    logic [NPORTS-1:0] r_rd_tick, w_rd_tick_nx;
    logic              r_rd_oe, w_rd_oe_nx;
    logic [PW-1:0]     r_port, w_port_nx;
    logic              r_rw_err, w_rw_err_nx;
    logic              w_fire;
    logic [NPORTS-1:0] w_onehot;

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_dir_nx     = r_dir;
        w_idx_nx     = r_idx;
        w_port_nx    = r_port;
        w_wr_tick_nx = '0;
        w_rd_tick_nx = '0;
        w_rd_oe_nx   = 1'b0;
        w_rw_err_nx  = 1'b0;
        w_fire       = 1'b0;
        w_onehot     = '0;

        case (r_state)
            WAIT_IDLE: begin
                if (w_vld && !r_iorq_s)
                    w_state_nx = IDLE;
            end
            IDLE: begin
                if (w_qual) begin
                    w_cnt_nx = 3'd1;
                    w_dir_nx = r_wr_s;
                    w_idx_nx = w_idx;
                    if (QUAL == 1) begin
                        w_fire     = 1'b1;
                        w_state_nx = BUSY;
                    end else begin
                        w_state_nx = QUALIFY;
                    end
                end else if (r_iorq_s) begin
                    w_state_nx  = BUSY;
                    w_rw_err_nx = r_rd_s && r_wr_s && !r_m1_s;
                end
            end
            QUALIFY: begin
                if (w_qual && (r_wr_s == r_dir) && (w_idx == r_idx)) begin
                    w_cnt_nx = r_cnt + 3'd1;
                    if (r_cnt + 3'd1 == 3'(QUAL)) begin
                        w_fire     = 1'b1;
                        w_state_nx = BUSY;
                    end
                end else if (r_iorq_s) begin
                    w_state_nx = BUSY;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            BUSY: begin
                w_rd_oe_nx = r_rd_oe && r_iorq_s && r_rd_s;
                if (!r_iorq_s)
                    w_state_nx = IDLE;
            end
            default: w_state_nx = WAIT_IDLE;
        endcase

        if (w_fire) begin
            w_onehot  = NPORTS'(1) << w_idx_nx;
            w_port_nx = w_idx_nx;
            if (w_dir_nx) begin
                w_wr_tick_nx = w_onehot;
            end else begin
                w_rd_tick_nx = w_onehot;
                w_rd_oe_nx   = 1'b1;
            end
        end
    end

    always_ff @(posedge phi or negedge reset) begin
        if (!reset) begin
            r_state   <= WAIT_IDLE;
            r_cnt     <= '0;
            r_dir     <= 1'b0;
            r_idx     <= '0;
            r_wr_tick <= '0;
            r_rd_tick <= '0;
            r_rd_oe   <= 1'b0;
            r_port    <= '0;
            r_rw_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_dir     <= w_dir_nx;
            r_idx     <= w_idx_nx;
            r_wr_tick <= w_wr_tick_nx;
            r_rd_tick <= w_rd_tick_nx;
            r_rd_oe   <= w_rd_oe_nx;
            r_port    <= w_port_nx;
            r_rw_err  <= w_rw_err_nx;
        end
    end

    assign wr_tick = r_wr_tick;
    assign rd_tick = r_rd_tick;
    assign rd_oe   = r_rd_oe;
    assign port    = r_port;
    assign rw_err  = r_rw_err;

endmodule

// File: tb/tb_iorq_rw_fsm.sv
// Bench for iorq_rw_fsm: QUAL=1 and QUAL=3 instances on a shared bus, each checked
// every cycle against an episode-level model, plus directed literal checks.
`timescale 1ns/1ps
module tb_iorq_rw_fsm;

    localparam int NP   = 4;
    localparam int BASE = 'h40;
`ifdef IORQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic       iorq;
        logic       rd;
        logic       wr;
        logic       m1;
        logic [7:0] addr;
    } samp_t;

    logic       phi   = 1'b0;
    logic       reset = 1'b0;
    logic       iorq  = 1'b0;
    logic       rd    = 1'b0;
    logic       wr    = 1'b0;
    logic       m1    = 1'b0;
    logic [7:0] addr  = 8'h00;

    logic [1:0][3:0] wr_tick_w, rd_tick_w;
    logic [1:0][1:0] port_w;
    logic [1:0]      rd_oe_w, rw_err_w;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #25 phi = ~phi;

    function automatic bit qualifies(input samp_t s);
        return s.iorq && !s.m1 && (s.rd ^ s.wr) && (s.addr >= BASE) && (s.addr < BASE + NP);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int Q = (g == 0) ? 1 : 3;

        iorq_rw_fsm #(.ADDR_W(8), .BASE(8'h40), .NPORTS(NP), .QUAL(Q)) u_dut (
            .phi(phi), .reset(reset), .iorq(iorq), .rd(rd), .wr(wr), .m1(m1), .addr(addr),
            .wr_tick(wr_tick_w[g]), .rd_tick(rd_tick_w[g]), .rd_oe(rd_oe_w[g]),
            .port(port_w[g]), .rw_err(rw_err_w[g])
        );

        // Model: an episode is a run of iorq samples after an idle sample; it ticks
        // once if its first Q samples all qualify for the same direction and port.
        samp_t      pipe[$];
        samp_t      ep[$];
        bit         armed;
        logic [3:0] e_wr, e_rd;
        logic [1:0] e_port;
        logic       e_oe, e_err;

        always @(posedge phi or negedge reset) begin
            samp_t s, cur;
            bit    tk, ok;
            if (!reset) begin
                pipe.delete();
                ep.delete();
                armed  = 1'b0;
                e_wr   = '0;
                e_rd   = '0;
                e_port = '0;
                e_oe   = 1'b0;
                e_err  = 1'b0;
            end else begin
                e_wr  = '0;
                e_rd  = '0;
                e_err = 1'b0;
                if (pipe.size() == LAT) begin
                    s  = pipe.pop_front();
                    tk = 1'b0;
                    if (!s.iorq) begin
                        armed = 1'b1;
                        ep.delete();
                    end else if (armed) begin
                        ep.push_back(s);
                        if (ep.size() == 1 && s.rd && s.wr && !s.m1)
                            e_err = 1'b1;
                        if (ep.size() == Q) begin
                            ok = 1'b1;
                            foreach (ep[i])
                                if (!qualifies(ep[i]) || ep[i].wr != ep[0].wr || ep[i].addr != ep[0].addr)
                                    ok = 1'b0;
                            tk = ok;
                        end
                    end
                    if (tk) begin
                        e_port = 2'(ep[0].addr - BASE);
                        if (ep[0].wr) e_wr = 4'b0001 << e_port;
                        else          e_rd = 4'b0001 << e_port;
                        e_oe = !ep[0].wr;
                    end else begin
                        e_oe = e_oe && s.iorq && s.rd;
                    end
                end
                cur = {iorq, rd, wr, m1, addr};
                pipe.push_back(cur);
            end
        end

        always @(negedge phi) begin
            if (chk_en) begin
                total++;
                if ({wr_tick_w[g], rd_tick_w[g], rd_oe_w[g], port_w[g], rw_err_w[g]} !==
                    {e_wr, e_rd, e_oe, e_port, e_err}) begin
                    bad++;
                    $display("FAIL q%0d_cycle t=%0t: got wr=%b rd=%b oe=%b port=%0d err=%b, want wr=%b rd=%b oe=%b port=%0d err=%b",
                             Q, $time, wr_tick_w[g], rd_tick_w[g], rd_oe_w[g], port_w[g], rw_err_w[g],
                             e_wr, e_rd, e_oe, e_port, e_err);
                end
            end
        end
    end

    // Activity monitor for the directed literal checks.
    int         mcyc;
    bit         mon_en = 1'b0;
    int         n_wr[2], n_rd[2], n_oe[2], n_err[2], first_wr[2];
    logic [3:0] or_wr[2], or_rd[2];

    always @(negedge phi) begin
        if (mon_en) begin
            mcyc++;
            for (int g = 0; g < 2; g++) begin
                if (wr_tick_w[g] != 4'b0) begin
                    n_wr[g]++;
                    or_wr[g] |= wr_tick_w[g];
                    if (first_wr[g] == 0) first_wr[g] = mcyc;
                end
                if (rd_tick_w[g] != 4'b0) begin
                    n_rd[g]++;
                    or_rd[g] |= rd_tick_w[g];
                end
                if (rd_oe_w[g])  n_oe[g]++;
                if (rw_err_w[g]) n_err[g]++;
            end
        end
    end

    task automatic mon_start();
        mcyc   = 0;
        mon_en = 1'b1;
        for (int g = 0; g < 2; g++) begin
            n_wr[g] = 0; n_rd[g] = 0; n_oe[g] = 0; n_err[g] = 0; first_wr[g] = 0;
            or_wr[g] = '0; or_rd[g] = '0;
        end
    endtask

    task automatic bus(input logic i, input logic r, input logic w, input logic m,
                       input logic [7:0] a, input int n);
        iorq = i; rd = r; wr = w; m1 = m; addr = a;
        repeat (n) @(posedge phi);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    initial begin
        int         kind, len, gap;
        logic [7:0] a;
        logic       w;

        @(posedge phi);
        chk_en = 1'b1;
        repeat (2) @(posedge phi);
        #1;
        check("reset wr_tick", int'(wr_tick_w[0]), 0);
        check("reset rd_oe",   int'(rd_oe_w[0]), 0);
        reset = 1'b1;
        bus(0, 0, 0, 0, 8'h00, 3);

        // Write to 0x42
        mon_start();
        bus(1, 0, 1, 0, 8'h42, 4);
        bus(0, 0, 0, 0, 8'h42, 4);
        check("wr42 count",      n_wr[0], 1);
        check("wr42 vec",        int'(or_wr[0]), 4);
        check("wr42 latency",    first_wr[0], LAT + 2);
        check("wr42 port",       int'(port_w[0]), 2);
        check("wr42 q3 count",   n_wr[1], 1);
        check("wr42 q3 latency", first_wr[1], LAT + 4);

        // Read from 0x41 with a wait state
        mon_start();
        bus(1, 1, 0, 0, 8'h41, 3);
        bus(0, 0, 0, 0, 8'h41, 5);
        check("rd41 count",    n_rd[0], 1);
        check("rd41 vec",      int'(or_rd[0]), 2);
        check("rd41 oe cyc",   n_oe[0], 3);
        check("rd41 q3 count", n_rd[1], 1);
        check("rd41 q3 oe",    n_oe[1], 1);

        // Miss and interrupt acknowledge
        mon_start();
        bus(1, 0, 1, 0, 8'h44, 3);
        bus(0, 0, 0, 0, 8'h44, 2);
        bus(1, 0, 0, 1, 8'h40, 3);
        bus(0, 0, 0, 0, 8'h40, 4);
        check("miss ticks", n_wr[0] + n_rd[0] + n_wr[1] + n_rd[1], 0);
        check("miss oe",    n_oe[0] + n_oe[1], 0);

        // Short write pulse then a full write
        mon_start();
        bus(1, 0, 1, 0, 8'h40, 2);
        bus(0, 0, 0, 0, 8'h40, 1);
        bus(1, 0, 1, 0, 8'h40, 4);
        bus(0, 0, 0, 0, 8'h40, 4);
        check("glitch q3 count", n_wr[1], 1);
        check("glitch q3 vec",   int'(or_wr[1]), 1);
        check("glitch q1 count", n_wr[0], 2);

        // rd and wr together
        mon_start();
        bus(1, 1, 1, 0, 8'h40, 2);
        bus(0, 0, 0, 0, 8'h40, 3);
        check("rwerr q1",    n_err[0], 1);
        check("rwerr q3",    n_err[1], 1);
        check("rwerr ticks", n_wr[0] + n_rd[0] + n_wr[1] + n_rd[1], 0);

        // Asynchronous reset during a read tick, released mid-write
        iorq = 1; rd = 1; wr = 0; m1 = 0; addr = 8'h41;
        repeat (LAT + 1) @(posedge phi);
        #1;
        check("inflight rd_tick", int'(rd_tick_w[0]), 2);
        check("inflight rd_oe",   int'(rd_oe_w[0]), 1);
        #5 reset = 1'b0;
        #1;
        check("async clr rd_tick", int'(rd_tick_w[0]), 0);
        check("async clr rd_oe",   int'(rd_oe_w[0]), 0);
        check("async clr port",    int'(port_w[0]), 0);
        rd = 0; wr = 1; addr = 8'h43;
        repeat (2) @(posedge phi);
        #1;
        mon_start();
        reset = 1'b1;
        bus(1, 0, 1, 0, 8'h43, 4);
        bus(0, 0, 0, 0, 8'h43, 2);
        bus(1, 0, 1, 0, 8'h43, 4);
        bus(0, 0, 0, 0, 8'h43, 3);
        check("rstmid q1 count", n_wr[0], 1);
        check("rstmid q1 vec",   int'(or_wr[0]), 8);
        check("rstmid q3 count", n_wr[1], 1);
        mon_en = 1'b0;

        // Randomised bus traffic
        for (int k = 0; k < 400; k++) begin
            kind = $urandom_range(0, 9);
            a    = 8'h3E + 8'($urandom_range(0, 8));
            len  = $urandom_range(1, 6);
            w    = 1'($urandom_range(0, 1));
            case (kind)
                0, 1, 2, 3: begin
                    bus(1, !w, w, 0, a, len);
                    if ($urandom_range(0, 3) == 0)
                        bus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, a ^ 8'h01, 2);
                    else if ($urandom_range(0, 3) == 0)
                        bus(1, 0, 0, 0, a, 1);
                end
                4: bus(1, 0, 0, 1, a, len);
                5: bus(1, 1, 1, 1'($urandom_range(0, 1)), a, len);
                6: begin
                    bus(1, 0, 0, 0, a, 1);
                    bus(1, !w, w, 0, a, len);
                end
                7: bus(1, !w, w, 0, a, 1);
                8: for (int j = 0; j < len; j++)
                       bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                           8'h3E + 8'($urandom_range(0, 8)), 1);
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        iorq = 1; rd = !w; wr = w; m1 = 0; addr = a;
                        #12 reset = 1'b0;
                        repeat (len) @(posedge phi);
                        #1;
                        reset = 1'b1;
                        bus(1, !w, w, 0, a, 2);
                    end else begin
                        bus(1, !w, w, 0, a, len);
                    end
                end
            endcase
            gap = $urandom_range(0, 3);
            if (gap > 0)
                bus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, a, gap);
        end

        bus(0, 0, 0, 0, 8'h00, 5);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
